// File: rtl/trace_pkg.sv
// trace_pkg: shared mode encoding and trace record layout
package trace_pkg;
    typedef enum logic [1:0] {
        MODE_ALL         = 2'd0,
        MODE_CHANGE_ONLY = 2'd1,
        MODE_PAUSE       = 2'd2,
        MODE_RSVD        = 2'd3
    } mode_e;
    // Records are packed {time, addr, data}, with time in the MSBs.
    function automatic int rec_w(input int ts_w, input int nreg, input int xlen);
        return ts_w + $clog2(nreg) + xlen;
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous first-word-fall-through FIFO with flush and level count
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;
    assign empty_o = level_q == '0;
    assign full_o  = level_q == LW'(DEPTH);
    assign do_pop  = pop_i && !empty_o && !flush_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i && !flush_i && (!full_o || do_pop);
    assign level_o = level_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];
    // Next pointer and level values; flush wins over push and pop.
    always_comb begin
        wr_d    = flush_i ? '0 : wr_q + AW'(do_push);
        rd_d    = flush_i ? '0 : rd_q + AW'(do_pop);
        level_d = flush_i ? '0 : level_q + LW'(do_push) - LW'(do_pop);
    end
    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end
    // Storage array; contents are only meaningful while counted in level.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/reg_write_tracer.sv
// reg_write_tracer: captures qualifying register-file writes as timestamped FIFO records
module reg_write_tracer
    import trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int DEPTH = 16,
    parameter int TS_W  = 16,
    parameter int OVF_W = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      wr_en_i,
    input  logic [$clog2(NREG)-1:0]   wr_addr_i,
    input  logic [XLEN-1:0]           wr_data_i,
    input  logic [1:0]                mode_i,
    input  logic [NREG-1:0]           reg_mask_i,
    input  logic                      flush_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [$clog2(NREG)-1:0]   out_addr_o,
    output logic [XLEN-1:0]           out_data_o,
    output logic [TS_W-1:0]           out_time_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic [OVF_W-1:0]          overflow_o
);
    localparam int RW = rec_w(TS_W, NREG, XLEN);
    logic [XLEN-1:0]  shadow_q [NREG];
    logic [TS_W-1:0]  ts_q;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic [RW-1:0]    rec_out;
    logic             qual, full, empty, drop, reg_write;
    mode_e            mode;
    assign mode      = mode_e'(mode_i);
    assign reg_write = wr_en_i && wr_addr_i != '0;
    // Change detection compares against the shadow value before this cycle's update.
    assign qual = reg_write && reg_mask_i[wr_addr_i] &&
                  (mode == MODE_ALL || (mode == MODE_CHANGE_ONLY && shadow_q[wr_addr_i] != wr_data_i));
    assign drop = qual && !flush_i && full && !(out_valid_o && out_ready_i);
    trace_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (resetn),
        .push_i  (qual),
        .pop_i   (out_ready_i),
        .flush_i (flush_i),
        .din_i   ({ts_q, wr_addr_i, wr_data_i}),
        .dout_o  (rec_out),
        .level_o (level_o),
        .full_o  (full),
        .empty_o (empty)
    );
    assign out_valid_o = !empty;
    assign {out_time_o, out_addr_o, out_data_o} = rec_out;
    assign overflow_o = ovf_q;
    // Saturating drop counter, cleared by flush.
    always_comb begin
        ovf_d = flush_i ? '0 : (drop && ovf_q != '1) ? ovf_q + OVF_W'(1) : ovf_q;
    end
    // Timestamp and overflow registers.
    always_ff @(posedge clk) begin
        if (resetn) begin
            ts_q  <= '0;
            ovf_q <= '0;
        end else begin
            ts_q  <= ts_q + TS_W'(1);
            ovf_q <= ovf_d;
        end
    end
    // Shadow register file follows every real write regardless of mode, mask or flush.
    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
        end else if (reg_write) begin
            shadow_q[wr_addr_i] <= wr_data_i;
        end
    end
endmodule

// File: tb/tb_reg_write_tracer.sv
// tb_reg_write_tracer: randomized and directed checks against a queue-based reference model
module tb_reg_write_tracer;
    localparam int XLEN = 32, NREG = 32, DEPTH = 16, TS_W = 16, OVF_W = 8;
    localparam int AW = 5, LW = 5;
    localparam int EW = 1 + LW + OVF_W + TS_W + AW + XLEN;
    logic clk = 1'b0;
    logic resetn, wr_en, flush, out_ready;
    logic [AW-1:0] wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [1:0] mode;
    logic [NREG-1:0] mask;
    logic out_valid;
    logic [AW-1:0] out_addr;
    logic [XLEN-1:0] out_data;
    logic [TS_W-1:0] out_time;
    logic [LW-1:0] level;
    logic [OVF_W-1:0] ovf;
    logic s_valid;
    logic [AW-1:0] s_addr;
    logic [XLEN-1:0] s_data;
    logic [3:0] s_time;
    logic [2:0] s_level;
    logic [1:0] s_ovf;
    int passed = 0, total = 0;
    typedef struct {
        logic [TS_W-1:0] t;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
    } rec_t;
    rec_t q[$];
    logic [XLEN-1:0] sh [NREG];
    int m_ovf, m_ts;

    always #5 clk = ~clk;

    reg_write_tracer #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .TS_W(TS_W), .OVF_W(OVF_W)) dut (
        .clk(clk), .resetn(resetn), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .mode_i(mode), .reg_mask_i(mask), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_addr_o(out_addr), .out_data_o(out_data),
        .out_time_o(out_time), .level_o(level), .overflow_o(ovf)
    );

    reg_write_tracer #(.XLEN(XLEN), .NREG(NREG), .DEPTH(4), .TS_W(4), .OVF_W(2)) dut_small (
        .clk(clk), .resetn(resetn), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .mode_i(mode), .reg_mask_i(mask), .flush_i(flush), .out_valid_o(s_valid),
        .out_ready_i(out_ready), .out_addr_o(s_addr), .out_data_o(s_data),
        .out_time_o(s_time), .level_o(s_level), .overflow_o(s_ovf)
    );

    // Advance the reference model with the current inputs, then clock the DUT.
    task automatic cycle();
        bit qual;
        if (resetn) begin
            q.delete();
            m_ovf = 0;
            m_ts = 0;
            foreach (sh[i]) sh[i] = '0;
        end else begin
            qual = wr_en && wr_addr != 0 && mask[wr_addr] &&
                   (mode == 2'd0 || (mode == 2'd1 && sh[wr_addr] != wr_data));
            if (flush) begin
                q.delete();
                m_ovf = 0;
            end else begin
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (qual) begin
                    if (q.size() < DEPTH) q.push_back('{TS_W'(m_ts), wr_addr, wr_data});
                    else if (m_ovf < (1 << OVF_W) - 1) m_ovf++;
                end
            end
            if (wr_en && wr_addr != 0) sh[wr_addr] = wr_data;
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        mode = 2'd0;
        mask = '1;
        cycle();
        cycle();
        resetn = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        wr_en = 1'b1;
        wr_addr = 5'd4;
        wr_data = 32'h99;
        flush = 1'b0;
        out_ready = 1'b0;
        mode = 2'd0;
        mask = '1;
        cycle();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0d want 0", out_valid); else passed++;
        do_reset();
        total++; if ({level, ovf} !== '0) $display("FAIL reset_level_ovf got %0d/%0d want 0/0", level, ovf); else passed++;
        total++; if ({out_addr, out_data, out_time} !== '0) $display("FAIL reset_outputs got %h/%h/%h want 0", out_addr, out_data, out_time); else passed++;
        total++; if ({s_valid, s_level, s_ovf} !== '0) $display("FAIL reset_small got %0d/%0d/%0d want 0", s_valid, s_level, s_ovf); else passed++;
    endtask

    task automatic test_first_write();
        do_reset();
        repeat (3) cycle();
        write(5'd5, 32'h0000_00AA);
        total++; if (out_valid !== 1'b1) $display("FAIL first_valid got %0d want 1", out_valid); else passed++;
        total++; if (out_addr !== 5'd5) $display("FAIL first_addr got %0d want 5", out_addr); else passed++;
        total++; if (out_data !== 32'hAA) $display("FAIL first_data got %h want aa", out_data); else passed++;
        total++; if (out_time !== 16'd3) $display("FAIL first_time got %0d want 3", out_time); else passed++;
        total++; if (level !== 5'd1) $display("FAIL first_level got %0d want 1", level); else passed++;
    endtask

    task automatic test_masked();
        do_reset();
        mask[7] = 1'b0;
        write(5'd0, 32'h1234);
        write(5'd7, 32'h55);
        cycle();
        total++; if ({out_valid, level} !== '0) $display("FAIL masked_no_record got %0d/%0d want 0/0", out_valid, level); else passed++;
        mask = '1;
        mode = 2'd1;
        write(5'd7, 32'h55);
        total++; if ({out_valid, level} !== '0) $display("FAIL masked_shadow got %0d/%0d want 0/0", out_valid, level); else passed++;
        write(5'd7, 32'h56);
        total++; if ({out_valid, out_addr, out_data} !== {1'b1, 5'd7, 32'h56}) $display("FAIL masked_change got %0d/%0d/%h want 1/7/56", out_valid, out_addr, out_data); else passed++;
    endtask

    task automatic test_change_only();
        do_reset();
        mode = 2'd1;
        write(5'd3, 32'h10);
        write(5'd3, 32'h10);
        write(5'd3, 32'h11);
        total++; if (level !== 5'd2) $display("FAIL change_level got %0d want 2", level); else passed++;
        total++; if (out_data !== 32'h10) $display("FAIL change_head got %h want 10", out_data); else passed++;
        out_ready = 1'b1;
        cycle();
        total++; if ({level, out_data} !== {5'd1, 32'h11}) $display("FAIL change_second got %0d/%h want 1/11", level, out_data); else passed++;
        cycle();
        total++; if ({out_valid, level} !== '0) $display("FAIL change_drained got %0d/%0d want 0/0", out_valid, level); else passed++;
        cycle();
        total++; if ({out_valid, level} !== '0) $display("FAIL change_underflow got %0d/%0d want 0/0", out_valid, level); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_overflow_and_flush();
        do_reset();
        for (int i = 0; i < 20; i++) write(5'((i % 31) + 1), 32'(i));
        total++; if (level !== 5'd16) $display("FAIL ovf_level got %0d want 16", level); else passed++;
        total++; if (ovf !== 8'd4) $display("FAIL ovf_count got %0d want 4", ovf); else passed++;
        out_ready = 1'b1;
        write(5'd9, 32'hBEEF);
        out_ready = 1'b0;
        total++; if ({level, ovf} !== {5'd16, 8'd4}) $display("FAIL full_push_pop got %0d/%0d want 16/4", level, ovf); else passed++;
        total++; if (out_data !== 32'd1) $display("FAIL full_push_pop_head got %h want 1", out_data); else passed++;
        flush = 1'b1;
        write(5'd10, 32'hCAFE);
        flush = 1'b0;
        total++; if ({out_valid, level, ovf} !== '0) $display("FAIL flush got %0d/%0d/%0d want 0/0/0", out_valid, level, ovf); else passed++;
        cycle();
        total++; if ({out_valid, level} !== '0) $display("FAIL flush_write_dropped got %0d/%0d want 0/0", out_valid, level); else passed++;
    endtask

    task automatic test_small_params();
        do_reset();
        for (int i = 0; i < 10; i++) write(5'(i + 1), 32'(i));
        total++; if ({s_level, s_ovf} !== {3'd4, 2'd3}) $display("FAIL small_saturate got %0d/%0d want 4/3", s_level, s_ovf); else passed++;
        total++; if ({level, ovf} !== {5'd10, 8'd0}) $display("FAIL big_no_ovf got %0d/%0d want 10/0", level, ovf); else passed++;
        do_reset();
        repeat (17) cycle();
        write(5'd9, 32'h77);
        total++; if ({s_valid, s_time} !== {1'b1, 4'd1}) $display("FAIL ts_wrap got %0d/%0d want 1/1", s_valid, s_time); else passed++;
        total++; if (out_time !== 16'd17) $display("FAIL ts_nowrap got %0d want 17", out_time); else passed++;
    endtask

    task automatic test_random();
        logic [EW-1:0] got, exp;
        bit ev;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom % 500) == 0;
            wr_en = ($urandom % 4) != 0;
            wr_addr = 5'($urandom_range(0, 7));
            wr_data = 32'($urandom_range(0, 3));
            if ($urandom % 40 == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom % 50 == 0) mask = {$urandom, $urandom} == 0 ? '1 : NREG'($urandom);
            out_ready = ($urandom % 3) == 0;
            flush = ($urandom % 100) == 0;
            cycle();
            ev = q.size() > 0;
            exp = {ev, LW'(q.size()), OVF_W'(m_ovf), ev ? {q[0].t, q[0].a, q[0].d} : {(TS_W + AW + XLEN){1'b0}}};
            got = {out_valid, level, ovf, out_time, out_addr, out_data};
            total++; if (got !== exp) $display("FAIL random cyc %0d got %h want %h", i, got, exp); else passed++;
        end
        resetn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_masked();
        test_change_only();
        test_overflow_and_flush();
        test_small_params();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
